// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter/sequencer for the shared clock/calendar ALU.
// Grants one of three requesters, holds it for ALU_LAT cycles, then pulses done.
module alu_request_arbiter #(
    parameter int ALU_LAT = 2,
    parameter int OP_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [3*OP_W-1:0] op_in,
    output logic [2:0]        pla,
    output logic [OP_W-1:0]   S,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic [2:0]        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [2:0]        pla_q, pla_d;
    logic [OP_W-1:0]   s_q, s_d;
    logic [1:0]        gid_q, gid_d;
    logic              busy_q, busy_d;
    logic [2:0]        done_q, done_d;

    logic [OP_W-1:0]   op_arr [3];
    logic [1:0]        pick;
    logic              pick_valid;
    logic [OP_W-1:0]   pick_op;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_op_split
            assign op_arr[gi] = op_in[gi*OP_W +: OP_W];
        end
    endgenerate

    // Search order is last+1, last+2, last+3 (mod 3); first asserted request wins.
    always_comb begin
        int idx;
        pick       = 2'd0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int j = 0; j < 3; j++) begin
            idx = (int'(last_q) + 1 + j) % 3;
            if (!pick_valid && req[idx]) begin
                pick       = 2'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        pick_op = '0;
        for (int k = 0; k < 3; k++) begin
            if (pick == 2'(k)) begin
                pick_op = op_arr[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pla_d   = pla_q;
        s_d     = s_q;
        gid_d   = gid_q;
        busy_d  = busy_q;
        done_d  = 3'b000;
        case (state_q)
            IDLE: begin
                pla_d  = 3'b000;
                s_d    = '0;
                gid_d  = 2'd0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    pla_d   = 3'b001 << pick;
                    s_d     = pick_op;
                    gid_d   = pick;
                    busy_d  = 1'b1;
                    cnt_d   = LAT_LOAD;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Op code was captured at grant time; op_in is ignored here.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    done_d  = pla_q;
                    last_d  = gid_q;
                    pla_d   = 3'b000;
                    s_d     = '0;
                    gid_d   = 2'd0;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pla_d   = 3'b000;
                s_d     = '0;
                gid_d   = 2'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 2'd2;
            pla_q   <= 3'b000;
            s_q     <= '0;
            gid_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pla_q   <= pla_d;
            s_q     <= s_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pla      = pla_q;
    assign S        = s_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Randomized + directed bench for alu_request_arbiter; two instances (ALU_LAT=2 and 1)
// are checked every cycle against a grant-schedule reference model.
module tb_alu_request_arbiter;

    localparam int OP_W = 2;

    logic              clk;
    logic              rst;
    logic [2:0]        req;
    logic [3*OP_W-1:0] op_in;

    logic [2:0]      pla_a, pla_b;
    logic [OP_W-1:0] s_a, s_b;
    logic [1:0]      gid_a, gid_b;
    logic            busy_a, busy_b;
    logic [2:0]      done_a, done_b;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model state: cycles elapsed in the current grant schedule (0 = free).
    int          m_phase [2];
    int          m_grant [2];
    int          m_last  [2];
    logic [1:0]  m_op    [2];

    alu_request_arbiter #(.ALU_LAT(2), .OP_W(OP_W)) dut_a (
        .clk(clk), .rst(rst), .req(req), .op_in(op_in),
        .pla(pla_a), .S(s_a), .grant_id(gid_a), .busy(busy_a), .done(done_a)
    );

    alu_request_arbiter #(.ALU_LAT(1), .OP_W(OP_W)) dut_b (
        .clk(clk), .rst(rst), .req(req), .op_in(op_in),
        .pla(pla_b), .S(s_b), .grant_id(gid_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int lst, input logic [2:0] r);
        for (int o = 1; o <= 3; o++) begin
            int k;
            k = (lst + o) % 3;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_check(input int i, input int lat, input logic [2:0] o_pla,
                               input logic [1:0] o_s, input logic [1:0] o_gid,
                               input logic o_busy, input logic [2:0] o_done);
        int e_pla, e_s, e_gid, e_busy, e_done;
        string nm;
        e_pla = 0; e_s = 0; e_gid = 0; e_busy = 0; e_done = 0;
        nm = (i == 0) ? "a" : "b";
        if (rst) begin
            m_phase[i] = 0;
            m_last[i]  = 2;
        end else if (m_phase[i] == 0) begin
            if (req != 3'b000) begin
                m_grant[i] = rr_pick(m_last[i], req);
                m_op[i]    = op_in[m_grant[i]*OP_W +: OP_W];
                m_phase[i] = 1;
            end
        end else begin
            m_phase[i]++;
        end
        if (!rst && m_phase[i] != 0) begin
            if (m_phase[i] <= lat) begin
                e_pla  = 1 << m_grant[i];
                e_s    = int'(m_op[i]);
                e_gid  = m_grant[i];
                e_busy = 1;
            end else if (m_phase[i] == lat + 1) begin
                e_done    = 1 << m_grant[i];
                m_last[i] = m_grant[i];
            end else begin
                m_phase[i] = 0;
            end
        end
        check_val({nm, ".pla"},  32'(o_pla),  e_pla);
        check_val({nm, ".S"},    32'(o_s),    e_s);
        check_val({nm, ".gid"},  32'(o_gid),  e_gid);
        check_val({nm, ".busy"}, 32'(o_busy), e_busy);
        check_val({nm, ".done"}, 32'(o_done), e_done);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_check(0, 2, pla_a, s_a, gid_a, busy_a, done_a);
        model_check(1, 1, pla_b, s_b, gid_b, busy_b, done_b);
        if (done_a != 3'b000)
            $display("txn cycle=%0d lat2 requester done=%b", cyc, done_a);
    endtask

    // Requester handshake against the ALU_LAT=2 instance: drop req on done, optionally re-assert.
    task automatic run_handshake(input int n, input logic [2:0] reassert);
        for (int c = 0; c < n; c++) begin
            tick();
            req = (req & ~done_a) | (done_a & reassert);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_grant[i] = 0; m_last[i] = 2; m_op[i] = 2'b00;
        end
        rst   = 1'b1;
        req   = 3'b000;
        op_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Single request from requester 0, op 10.
        req   = 3'b001;
        op_in = 6'b00_00_10;
        run_handshake(8, 3'b000);
        req = 3'b000;
        repeat (2) tick();

        // All three continuously requesting.
        req   = 3'b111;
        op_in = 6'b11_01_10;
        run_handshake(24, 3'b111);
        req = 3'b000;
        repeat (4) tick();

        // Op change during grant is ignored.
        req   = 3'b010;
        op_in = 6'b00_01_00;
        tick();
        tick();
        op_in = 6'b00_11_00;
        run_handshake(6, 3'b000);
        req = 3'b000;
        repeat (3) tick();

        // Requester 2 drops one cycle into its grant.
        req   = 3'b100;
        op_in = 6'b10_00_00;
        tick();
        tick();
        req = 3'b000;
        repeat (6) tick();

        // Reset during a grant to requester 1, then 011 must go to requester 0 first.
        req   = 3'b010;
        op_in = 6'b01_10_11;
        for (int w = 0; w < 12 && pla_a != 3'b010; w++) tick();
        check_val("wait_grant1", 32'(pla_a), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b011;
        tick();
        check_val("post_rst_grant0", 32'(pla_a), 32'h1);
        run_handshake(12, 3'b000);

        // Requesters 1 and 2 together (ALU_LAT=1 instance covers the short grant).
        req = 3'b110;
        run_handshake(12, 3'b110);
        req = 3'b000;
        repeat (3) tick();

        // Randomized traffic with occasional resets and mid-grant drops.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (done_a[k] && ($urandom % 4 != 0)) req[k] = 1'b0;
                else if (!req[k] && ($urandom % 4 == 0)) req[k] = 1'b1;
                else if (req[k] && ($urandom % 32 == 0)) req[k] = 1'b0;
            end
            op_in = 6'($urandom);
            rst   = ($urandom % 97 == 0);
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
